// File: rtl/muldiv_unit_if.sv
`default_nettype none
// =============================================================================
// muldiv_if: operand/control/result bundle between execute stage and muldiv_unit
// Rev 1.0
// =============================================================================
package cpu_types_pkg;
    typedef logic [31:0] word_t;
endpackage

interface muldiv_if;
    import cpu_types_pkg::*;

    logic       start;
    logic [1:0] op;
    word_t      portA;
    word_t      portB;
    logic       flush;
    logic       hi_we;
    logic       lo_we;
    word_t      wdata;
    logic       busy;
    logic       done;
    word_t      hi;
    word_t      lo;

    modport master (
        output start, op, portA, portB, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, portA, portB, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// =============================================================================
// muldiv_unit: 32-iteration radix-2 MULT/MULTU/DIV/DIVU with HI/LO registers.
// Define MULDIV_DIV_EN to build the divider.  Rev 1.0
// =============================================================================
module muldiv_unit (
    input  logic     CLK,
    input  logic     nRST,
    muldiv_if.slave  bus
);
    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    word_t       m_q, m_d;
    logic        neg_q, neg_d;
    word_t       hi_q, hi_d;
    word_t       lo_q, lo_d;
`ifdef MULDIV_DIV_EN
    logic        is_div_q, is_div_d;
    logic        rneg_q, rneg_d;
    logic [32:0] w_div_trial;
    logic [63:0] w_div_step;
`endif

    logic        w_accept;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic        w_last;
    word_t       w_abs_a;
    word_t       w_abs_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_step;
    logic [63:0] w_step;
    logic [63:0] w_prod;
    word_t       w_res_hi;
    word_t       w_res_lo;

    assign w_accept = (state_q != S_RUN) && bus.start && !bus.flush;
    assign w_signed = ~bus.op[0];
    assign w_a_neg  = w_signed & bus.portA[31];
    assign w_b_neg  = w_signed & bus.portB[31];
    assign w_abs_a  = w_a_neg ? (32'd0 - bus.portA) : bus.portA;
    assign w_abs_b  = w_b_neg ? (32'd0 - bus.portB) : bus.portB;
    assign w_last   = (count_q == 5'd31);

    // Multiply: multiplier sits in acc[31:0] and is consumed LSB-first while
    // the partial product grows in from the top.
    assign w_mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, m_q};
    assign w_mul_step = acc_q[0] ? {w_mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

`ifdef MULDIV_DIV_EN
    // Divide: remainder in acc[63:32], dividend shifts out as quotient shifts in.
    assign w_div_trial = acc_q[63:31] - {1'b0, m_q};
    assign w_div_step  = w_div_trial[32] ? {acc_q[62:0], 1'b0}
                                         : {w_div_trial[31:0], acc_q[30:0], 1'b1};
    assign w_step      = is_div_q ? w_div_step : w_mul_step;
`else
    assign w_step      = w_mul_step;
`endif

    always_comb begin
        w_prod   = neg_q ? (64'd0 - w_step) : w_step;
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
            w_res_lo = neg_q  ? (32'd0 - w_step[31:0])  : w_step[31:0];
            w_res_hi = rneg_q ? (32'd0 - w_step[63:32]) : w_step[63:32];
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        m_d      = m_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef MULDIV_DIV_EN
        is_div_d = is_div_q;
        rneg_d   = rneg_q;
`endif

        if (state_q != S_RUN) begin
            if (bus.hi_we) hi_d = bus.wdata;
            if (bus.lo_we) lo_d = bus.wdata;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (w_accept) begin
                    count_d = 5'd0;
                    if (bus.op[1]) begin
`ifdef MULDIV_DIV_EN
                        // A zero divisor must leave the all-ones quotient
                        // unnegated; the remainder naturally returns portA.
                        is_div_d = 1'b1;
                        m_d      = w_abs_b;
                        acc_d    = {32'd0, w_abs_a};
                        neg_d    = (w_a_neg ^ w_b_neg) && (bus.portB != 32'd0);
                        rneg_d   = w_a_neg;
                        state_d  = S_RUN;
`else
                        state_d  = S_DONE;
`endif
                    end else begin
`ifdef MULDIV_DIV_EN
                        is_div_d = 1'b0;
                        rneg_d   = 1'b0;
`endif
                        m_d      = w_abs_a;
                        acc_d    = {32'd0, w_abs_b};
                        neg_d    = w_a_neg ^ w_b_neg;
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = w_step;
                    count_d = count_q + 5'd1;
                    if (w_last) begin
                        state_d = S_DONE;
                        hi_d    = w_res_hi;
                        lo_d    = w_res_lo;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            count_q  <= 5'd0;
            acc_q    <= 64'd0;
            m_q      <= 32'd0;
            neg_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
`ifdef MULDIV_DIV_EN
            is_div_q <= 1'b0;
            rneg_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            m_q      <= m_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MULDIV_DIV_EN
            is_div_q <= is_div_d;
            rneg_q   <= rneg_d;
`endif
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// =============================================================================
// tb_muldiv_unit: directed vector table plus control-path sequences for muldiv_unit
// Rev 1.0
// =============================================================================
module tb_muldiv_unit;

    logic clk;
    logic nrst;
    int   n_checks;
    int   n_err;

    muldiv_if bus ();

    muldiv_unit dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [12];

`ifdef MULDIV_DIV_EN
    localparam bit DIV_BUILT = 1'b1;
`else
    localparam bit DIV_BUILT = 1'b0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps edges until done is seen or the budget runs out.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 0;
        busy_cnt = 0;
        while (!bus.done && edges < 100) begin
            if (bus.busy) busy_cnt++;
            tick();
            edges++;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int edges, output int busy_cnt);
        bus.op    = op;
        bus.portA = a;
        bus.portB = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.portA = 32'hDEAD_BEEF;
        bus.portB = 32'h0BAD_F00D;
        bus.op    = ~op;
        wait_done(edges, busy_cnt);
    endtask

    initial begin
        logic [31:0] m_hi, m_lo, e_hi, e_lo;
        int          edges, busy_cnt, exp_busy;
        bit          saw_done;

        n_checks = 0;
        n_err    = 0;
        // op, portA, portB, hi, lo
        vecs[0]  = '{2'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{2'd0, 32'h0000_0007, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFDD};
        vecs[3]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[4]  = '{2'd1, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[5]  = '{2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[6]  = '{2'd3, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        vecs[7]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[8]  = '{2'd3, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999};
        vecs[9]  = '{2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[10] = '{2'd2, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF};
        vecs[11] = '{2'd1, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006};

        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.portA = 32'd0;
        bus.portB = 32'd0;
        bus.flush = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = 32'd0;
        nrst      = 1'b0;
        repeat (3) tick();
        check("reset_busy", {63'd0, bus.busy}, 64'd0);
        check("reset_done", {63'd0, bus.done}, 64'd0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        nrst = 1'b1;
        tick();

        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].op[1] && !DIV_BUILT) begin
                e_hi     = m_hi;
                e_lo     = m_lo;
                exp_busy = 0;
            end else begin
                e_hi     = vecs[i].hi;
                e_lo     = vecs[i].lo;
                exp_busy = 32;
            end
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, edges, busy_cnt);
            check($sformatf("v%0d_done", i), {63'd0, bus.done}, 64'd1);
            check($sformatf("v%0d_busycycles", i), 64'(busy_cnt), 64'(exp_busy));
            check($sformatf("v%0d_hilo", i), {bus.hi, bus.lo}, {e_hi, e_lo});
            m_hi = e_hi;
            m_lo = e_lo;
            tick();
            check($sformatf("v%0d_done_pulse", i), {62'd0, bus.done, bus.busy}, 64'd0);
        end

        // MTHI then MTLO
        bus.wdata = 32'h0000_1234;
        bus.hi_we = 1'b1;
        tick();
        bus.hi_we = 1'b0;
        bus.wdata = 32'h0000_5678;
        bus.lo_we = 1'b1;
        tick();
        bus.lo_we = 1'b0;
        check("mthi_mtlo", {bus.hi, bus.lo}, {32'h0000_1234, 32'h0000_5678});

        // Flush ten cycles into a MULT
        bus.op    = 2'd0;
        bus.portA = 32'd3;
        bus.portB = 32'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        check("flush_pre_busy", {63'd0, bus.busy}, 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_idle", {62'd0, bus.busy, bus.done}, 64'd0);
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) saw_done = 1'b1;
            tick();
        end
        check("flush_no_done", {63'd0, saw_done}, 64'd0);
        check("flush_hilo_kept", {bus.hi, bus.lo}, {32'h0000_1234, 32'h0000_5678});

        // start together with flush in IDLE is ignored
        bus.op    = 2'd1;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("idle_flush_start", {62'd0, bus.busy, bus.done}, 64'd0);

        // MTHI while RUN is ignored, result arrives normally
        bus.op    = 2'd1;
        bus.portA = 32'd2;
        bus.portB = 32'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        bus.wdata = 32'hAAAA_AAAA;
        bus.hi_we = 1'b1;
        tick();
        bus.hi_we = 1'b0;
        check("hi_we_in_run", {32'd0, bus.hi}, {32'd0, 32'h0000_1234});
        wait_done(edges, busy_cnt);
        check("b2b_first_done", {63'd0, bus.done}, 64'd1);
        check("b2b_first_lo", {bus.hi, bus.lo}, {32'd0, 32'd6});

        // Second start issued during the DONE cycle
        run_op(2'd1, 32'd4, 32'd5, edges, busy_cnt);
        check("b2b_interval", 64'(edges + 1), 64'd33);
        check("b2b_second_lo", {bus.hi, bus.lo}, {32'd0, 32'd20});

        // Asynchronous reset mid-operation
        tick();
        bus.op    = 2'd0;
        bus.portA = 32'd5;
        bus.portB = 32'd6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        #2;
        nrst = 1'b0;
        #1;
        check("rst_mid_busy", {62'd0, bus.busy, bus.done}, 64'd0);
        check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        tick();
        nrst = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done || bus.busy) saw_done = 1'b1;
            tick();
        end
        check("rst_mid_quiet", {63'd0, saw_done}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit sitting in the execute stage beside the ALU, fed from the same operand muxes as the ALU's portA/portB. Executes MULT, MULTU, DIV and DIVU over 32 iterations, holds results in architectural HI/LO registers, and supports MTHI/MTLO writes. The downstream hazard unit stalls the pipeline on busy, and MFHI/MFLO read the hi/lo outputs directly.

## Interface
Parameters:
- none; width fixed at 32 bits by word_t from cpu_types_pkg

Ports:
- CLK  input  1  rising-edge clock
- nRST  input  1  asynchronous active-low reset
- start  input  1  request an operation; sampled only when accepting (IDLE or DONE state)
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- portA  input  32  multiplicand / dividend (word_t)
- portB  input  32  multiplier / divisor (word_t)
- flush  input  1  synchronous abort of an in-flight operation
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  32  MTHI/MTLO data
- busy  output  1  operation in flight (RUN state)
- done  output  1  one-cycle pulse; hi/lo hold the new result this cycle
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 and flush=0: latch op, |portA|, |portB| (absolute values for signed ops; raw for unsigned), result sign flags; count <= 0; go RUN. Otherwise DONE -> IDLE.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract producing a 32-bit quotient and a 32-bit remainder.
  - After the 32nd step (count==31): go DONE.
- Entry to DONE: sign correction applied, then hi/lo written.
  - MULT/MULTU: {hi,lo} = 64-bit product; two's complement negation if signs differ (MULT only).
  - DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
- Special cases:
  - Divisor 0: lo = 32'hFFFFFFFF, hi = original portA; same latency.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- flush in RUN or DONE: next state IDLE; hi/lo unchanged; no done pulse. flush in IDLE has no effect, and start in the same cycle is ignored.
- hi_we/lo_we: write wdata on the clock edge in any state except RUN; ignored in RUN.
  - If a write coincides with the done-cycle update, the result update wins.
  - A write and a start in the same cycle both take effect; the later result overwrites.
- Operands are latched at start; portA/portB/op may change freely afterward.

## Timing
- Reset (nRST low, asynchronous): state IDLE, busy=0, done=0, hi=0, lo=0, count=0.
- Reset mid-operation aborts immediately; the result is discarded.
- start sampled at edge k: busy=1 for cycles k+1..k+32; at edge k+33, hi/lo are updated, done=1, and busy=0 during cycle k+33. Latency is 33 cycles from start edge to result.
- Back-to-back: start asserted during the DONE cycle is accepted at that edge; busy rises the next cycle. Issue interval is 33 cycles.
- busy and done are registered (decoded from state); never both high.
- start during RUN is ignored. The requester must hold start until busy is seen, or re-issue it.

## Configuration
- MULDIV_DIV_EN defined: full divide datapath as above.
- MULDIV_DIV_EN undefined: divider logic omitted. DIV/DIVU start goes directly to DONE at the next edge: done pulses one cycle later, busy never rises, hi/lo unchanged. MULT/MULTU unaffected.

## Test plan
- MULT 0xFFFFFFFE (-2) x 0x00000003, start at cycle 0 -> busy cycles 1..32, done at 33, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/0 -> lo=0xFFFFFFFF, hi=100.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Control:
  - flush at cycle 10 of a MULT -> IDLE next cycle, no done, hi/lo retain prior MTHI/MTLO values (0x1234/0x5678).
  - hi_we during RUN -> ignored.
  - nRST low at cycle 5 -> hi=lo=0, busy=0 immediately.
- Back-to-back: second start during the done cycle -> second done exactly 33 cycles after the first. With MULTU 2x3 then MULTU 4x5 -> lo=6 then lo=20.
